alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width.
REQ-002 Parameter N_REG_BITS, default 5, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream (decode) holds a valid instruction.
REQ-006 in_ready  output  1  stage can accept; registered.
REQ-007 opcode  input  7  RISC-V opcode field.
REQ-008 funct3  input  3  RISC-V funct3.
REQ-009 funct7_5  input  1  instruction bit 30.
REQ-010 rs1_data, rs2_data  input  XLEN each  register-file read data.
REQ-011 imm  input  XLEN  sign-extended immediate.
REQ-012 rd  input  N_REG_BITS  destination register index.
REQ-013 flush  input  1  discard all held instructions.
REQ-014 out_valid  output  1  operands presented to the ALU are valid.
REQ-015 out_ready  input  1  ALU/EX-MEM side consumes this cycle.
REQ-016 out_a, out_b  output  XLEN each  ALU operands A, B.
REQ-017 out_alu_op  output  4  ALU_Op {Ainv, Binv, Op[1:0]}.
REQ-018 out_rd, out_store_data (XLEN), out_is_branch, out_is_store, out_illegal  output  side-band carried with operands.

Function
REQ-019 ALU_Op encoding SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-020 Decode SHALL map: opcode 0110011 (R-type) funct3 000 -> ADD, or SUB when funct7_5=1; 111 -> AND; 110 -> OR; 010 -> SLT.
REQ-021 Opcode 0010011 (I-type) SHALL map funct3 000/111/110/010 to ADD/AND/OR/SLT, funct7_5 ignored.
REQ-022 Opcodes 0000011 (load) and 0100011 (store) SHALL map to ADD; store sets out_is_store=1 and out_store_data=rs2_data.
REQ-023 Opcode 1100011 funct3 000 (beq) SHALL map to SUB with out_is_branch=1.
REQ-024 Any other opcode/funct3 combination SHALL set out_illegal=1, out_alu_op=ADD, all other flags 0.
REQ-025 out_a SHALL be rs1_data; out_b SHALL be rs2_data for R-type and beq, imm otherwise.
REQ-026 Transfer SHALL occur on an input side only when in_valid && in_ready, on the output side only when out_valid && out_ready.
REQ-027 Stage SHALL be a two-entry skid buffer (main, skid) with states EMPTY, ONE, TWO.
REQ-028 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-029 ONE: accept and consume -> ONE (main reloaded); accept only -> TWO (new entry to skid); consume only -> EMPTY; neither -> ONE.
REQ-030 TWO: consume -> ONE (skid moves to main); no consume -> TWO. No input accepted in TWO.
REQ-031 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, registered from next state.
REQ-032 out_valid SHALL be 1 in ONE and TWO; outputs SHALL reflect main entry and remain stable while out_valid && !out_ready.
REQ-033 Latency SHALL be one cycle from accept to out_valid when EMPTY; sustained throughput one per cycle with out_ready held high.
REQ-034 Ordering SHALL be strict FIFO; no instruction duplicated or dropped except by flush.
REQ-035 flush SHALL force EMPTY next cycle, overriding any simultaneous accept (input dropped) and consume; in_ready=1 next cycle.
REQ-036 Side-band flags SHALL be zero whenever out_valid=0.

Reset
REQ-037 On rst_n low, state SHALL go EMPTY asynchronously: out_valid=0, in_ready=1, all data and flag outputs 0.
REQ-038 Reset asserted mid-transfer SHALL discard both entries; first accept after rst_n rises is the next instruction to appear.

Structure
REQ-039 ALU_Op codes, opcode constants, and state enumeration SHALL live in shared package alu_pkg.
REQ-040 Decode (REQ-020..025) SHALL be a combinational sub-module alu_ctrl_decode; skid buffer and FSM in alu_issue_stage.

Verification
REQ-041 R-type sub, rs1=10, rs2=3, funct7_5=1, out_ready=1 -> next cycle out_valid=1, out_alu_op=0110, out_a=10, out_b=3.
REQ-042 addi imm=-1 (all ones), rs1=5 -> out_b=0xFFFF_FFFF_FFFF_FFFF, out_alu_op=0010.
REQ-043 Three back-to-back accepts, out_ready=0 -> third refused (in_ready=0 after second); release out_ready -> outputs appear in order 1,2 then third accepted.
REQ-044 flush in TWO state with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry later emitted.
REQ-045 opcode 1110011 -> out_illegal=1, out_alu_op=0010; beq -> out_is_branch=1, out_alu_op=0110.
REQ-046 rst_n low while in TWO -> out_valid=0, in_ready=1 without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU issue-stage definitions: ALU_Op codes, RISC-V opcode/funct3
// constants and the skid-buffer state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic logic arith_f3_legal(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

    // Caller must have checked arith_f3_legal; anything else falls back to ADD.
    function automatic alu_op_t arith_op(input logic [2:0] f3, input logic sub);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = sub ? ALU_SUB : ALU_ADD;
            F3_SLT:  op = ALU_SLT;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side and ALU-side handshake bundle of the ALU issue stage.
// valid/ready: a beat transfers on a rising edge exactly when valid && ready are both 1.
interface alu_issue_stage_if #(
    parameter int XLEN       = 64,
    parameter int N_REG_BITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7_5;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [N_REG_BITS-1:0] rd;
    logic                  flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_a;
    logic [XLEN-1:0]       out_b;
    logic [3:0]            out_alu_op;
    logic [N_REG_BITS-1:0] out_rd;
    logic [XLEN-1:0]       out_store_data;
    logic                  out_is_branch;
    logic                  out_is_store;
    logic                  out_illegal;

    modport slave (
        input  in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, rd, flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_store_data,
               out_is_branch, out_is_store, out_illegal
    );

    modport master (
        output in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, rd, flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_store_data,
               out_is_branch, out_is_store, out_illegal
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: opcode/funct3/funct7_5 to ALU_Op, operand
// selection and side-band flags.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] store_data,
    output logic            is_branch,
    output logic            is_store,
    output logic            illegal
);

    logic use_rs2;

    always_comb begin
        alu_op     = ALU_ADD;
        use_rs2    = 1'b0;
        store_data = '0;
        is_branch  = 1'b0;
        is_store   = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OPC_R: begin
                use_rs2 = 1'b1;
                if (arith_f3_legal(funct3)) alu_op = arith_op(funct3, funct7_5);
                else                        illegal = 1'b1;
            end
            OPC_I: begin
                if (arith_f3_legal(funct3)) alu_op = arith_op(funct3, 1'b0);
                else                        illegal = 1'b1;
            end
            OPC_LOAD: alu_op = ALU_ADD;
            OPC_STORE: begin
                alu_op     = ALU_ADD;
                is_store   = 1'b1;
                store_data = rs2_data;
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    alu_op    = ALU_SUB;
                    is_branch = 1'b1;
                    use_rs2   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    assign a = rs1_data;
    assign b = use_rs2 ? rs2_data : imm;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an instruction and holds it in a two-entry skid
// buffer (main, skid) so in_ready can be registered without losing throughput.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int N_REG_BITS = 5
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_issue_stage_if.slave io,
    output state_t dbg_state
);

    typedef struct packed {
        logic [XLEN-1:0]       a;
        logic [XLEN-1:0]       b;
        logic [3:0]            alu_op;
        logic [N_REG_BITS-1:0] rd;
        logic [XLEN-1:0]       store_data;
        logic                  is_branch;
        logic                  is_store;
        logic                  illegal;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t dec;
    logic   in_ready_q, in_ready_d;
    logic   out_valid;
    logic   accept, consume;

    alu_ctrl_decode #(.XLEN(XLEN)) u_decode (
        .opcode     (io.opcode),
        .funct3     (io.funct3),
        .funct7_5   (io.funct7_5),
        .rs1_data   (io.rs1_data),
        .rs2_data   (io.rs2_data),
        .imm        (io.imm),
        .a          (dec.a),
        .b          (dec.b),
        .alu_op     (dec.alu_op),
        .store_data (dec.store_data),
        .is_branch  (dec.is_branch),
        .is_store   (dec.is_store),
        .illegal    (dec.illegal)
    );
    assign dec.rd = io.rd;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = io.in_valid && in_ready_q;
    assign consume   = out_valid && io.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = dec;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_d = dec;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = dec;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the drain direction can move.
                if (consume) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        if (io.flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Gating by out_valid keeps every output at zero while the stage is empty,
    // including immediately on asynchronous reset.
    assign io.in_ready       = in_ready_q;
    assign io.out_valid      = out_valid;
    assign io.out_a          = out_valid ? main_q.a          : '0;
    assign io.out_b          = out_valid ? main_q.b          : '0;
    assign io.out_alu_op     = out_valid ? main_q.alu_op     : '0;
    assign io.out_rd         = out_valid ? main_q.rd         : '0;
    assign io.out_store_data = out_valid ? main_q.store_data : '0;
    assign io.out_is_branch  = out_valid && main_q.is_branch;
    assign io.out_is_store   = out_valid && main_q.is_store;
    assign io.out_illegal    = out_valid && main_q.illegal;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions with hand-computed
// expected operands; a monitor pops and compares on every output transfer.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int XLEN = 64;
    localparam int NR   = 5;
    localparam int W    = 3*XLEN + 4 + NR + 3;
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     checks;
    int     errors;
    logic [W-1:0] exp_q[$];

    alu_issue_stage_if #(.XLEN(XLEN), .N_REG_BITS(NR)) bus ();

    alu_issue_stage #(.XLEN(XLEN), .N_REG_BITS(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                          input logic [3:0] op, input logic [NR-1:0] rd,
                                          input logic [XLEN-1:0] sd, input logic br,
                                          input logic st, input logic il);
        return {a, b, op, rd, sd, br, st, il};
    endfunction

    function automatic logic [W-1:0] observed();
        return {bus.out_a, bus.out_b, bus.out_alu_op, bus.out_rd, bus.out_store_data,
                bus.out_is_branch, bus.out_is_store, bus.out_illegal};
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: presents one instruction, waits for in_ready, queues the expected beat.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                        input logic [XLEN-1:0] imm, input logic [NR-1:0] rd,
                        input logic push, input logic [W-1:0] exp);
        int n;
        @(negedge clk);
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
        bus.rs1_data = rs1;
        bus.rs2_data = rs2;
        bus.imm      = imm;
        bus.rd       = rd;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for rd=%0d", rd);
        end else if (push) begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", XLEN'(exp_q.size()), '0);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h with empty queue", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin
                        errors++;
                        $display("FAIL output_beat: got %h expected %h", observed(), e);
                    end
                end
            end else if (!bus.out_valid) begin
                checks++;
                if (observed() !== '0) begin
                    errors++;
                    $display("FAIL idle_outputs_zero: got %h expected 0", observed());
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.opcode = '0;
        bus.funct3 = '0;
        bus.funct7_5 = 1'b0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.imm = '0;
        bus.rd = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", XLEN'(bus.out_valid), '0);
        chk("reset_in_ready", XLEN'(bus.in_ready), 1);
        chk("reset_out_a", bus.out_a, '0);
        chk("reset_state", XLEN'(dbg_state), XLEN'(ST_EMPTY));
        rst_n = 1'b1;

        // Decode coverage with out_ready held high
        bus.out_ready = 1'b1;
        send(OPC_R, 3'b000, 1'b1, 10, 3, 'h100, 1, 1'b1, pack(10, 3, 4'b0110, 1, 0, 0, 0, 0));
        @(negedge clk);
        chk("latency_out_valid", XLEN'(bus.out_valid), 1);
        chk("latency_alu_op", XLEN'(bus.out_alu_op), 4'b0110);
        send(OPC_I, 3'b000, 1'b0, 5, 77, ONES, 2, 1'b1, pack(5, ONES, 4'b0010, 2, 0, 0, 0, 0));
        send(OPC_R, 3'b000, 1'b0, 7, 8, 'h55, 3, 1'b1, pack(7, 8, 4'b0010, 3, 0, 0, 0, 0));
        send(OPC_R, 3'b111, 1'b0, 'hF0F0, 'hFF00, 1, 4, 1'b1, pack('hF0F0, 'hFF00, 4'b0000, 4, 0, 0, 0, 0));
        send(OPC_R, 3'b110, 1'b0, 1, 2, 0, 5, 1'b1, pack(1, 2, 4'b0001, 5, 0, 0, 0, 0));
        send(OPC_R, 3'b010, 1'b0, ONES - 1, 4, 0, 6, 1'b1, pack(ONES - 1, 4, 4'b0111, 6, 0, 0, 0, 0));
        send(OPC_I, 3'b111, 1'b1, 'h1234, 'h99, 'hF0, 7, 1'b1, pack('h1234, 'hF0, 4'b0000, 7, 0, 0, 0, 0));
        send(OPC_I, 3'b110, 1'b0, 3, 0, 'h40, 8, 1'b1, pack(3, 'h40, 4'b0001, 8, 0, 0, 0, 0));
        send(OPC_I, 3'b010, 1'b0, 9, 0, 10, 9, 1'b1, pack(9, 10, 4'b0111, 9, 0, 0, 0, 0));
        send(OPC_LOAD, 3'b011, 1'b0, 'h1000, 'h77, 8, 10, 1'b1, pack('h1000, 8, 4'b0010, 10, 0, 0, 0, 0));
        send(OPC_STORE, 3'b011, 1'b0, 'h2000, 'hABCD, 16, 11, 1'b1, pack('h2000, 16, 4'b0010, 11, 'hABCD, 0, 1, 0));
        send(OPC_BRANCH, 3'b000, 1'b0, 9, 9, ONES - 7, 0, 1'b1, pack(9, 9, 4'b0110, 0, 0, 1, 0, 0));
        send(7'b1110011, 3'b000, 1'b0, 'h33, 'h44, 'h55, 12, 1'b1, pack('h33, 'h55, 4'b0010, 12, 0, 0, 0, 1));
        send(OPC_I, 3'b001, 1'b0, 1, 0, 3, 13, 1'b1, pack(1, 3, 4'b0010, 13, 0, 0, 0, 1));
        drain();

        // Backpressure: third instruction must wait until the buffer drains
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(OPC_R, 3'b000, 1'b0, 'h11, 'h22, 0, 14, 1'b1, pack('h11, 'h22, 4'b0010, 14, 0, 0, 0, 0));
        send(OPC_I, 3'b000, 1'b0, 'h21, 0, 5, 15, 1'b1, pack('h21, 5, 4'b0010, 15, 0, 0, 0, 0));
        @(negedge clk);
        chk("two_in_ready_low", XLEN'(bus.in_ready), '0);
        chk("two_state", XLEN'(dbg_state), XLEN'(ST_TWO));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("stall_out_valid", XLEN'(bus.out_valid), 1);
            chk("stall_out_a_stable", bus.out_a, 'h11);
        end
        bus.out_ready = 1'b1;
        send(OPC_R, 3'b000, 1'b1, 100, 1, 0, 16, 1'b1, pack(100, 1, 4'b0110, 16, 0, 0, 0, 0));
        drain();

        // Flush in TWO with a simultaneous input
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(OPC_R, 3'b000, 1'b0, 1, 1, 0, 20, 1'b0, '0);
        send(OPC_R, 3'b000, 1'b0, 2, 2, 0, 21, 1'b0, '0);
        @(negedge clk);
        chk("pre_flush_state", XLEN'(dbg_state), XLEN'(ST_TWO));
        bus.rd = 22;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", XLEN'(bus.out_valid), '0);
        chk("flush_in_ready", XLEN'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("flush_stays_empty", XLEN'(bus.out_valid), '0);
        end

        // Asynchronous reset while holding two entries
        bus.out_ready = 1'b0;
        send(OPC_R, 3'b000, 1'b0, 3, 3, 0, 23, 1'b0, '0);
        send(OPC_R, 3'b000, 1'b0, 4, 4, 0, 24, 1'b0, '0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", XLEN'(bus.out_valid), '0);
        chk("async_rst_in_ready", XLEN'(bus.in_ready), 1);
        chk("async_rst_out_a", bus.out_a, '0);
        chk("async_rst_state", XLEN'(dbg_state), XLEN'(ST_EMPTY));
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(OPC_R, 3'b110, 1'b0, 'hA, 5, 0, 17, 1'b1, pack('hA, 5, 4'b0001, 17, 0, 0, 0, 0));
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
